// File: rtl/sad_pkg.sv
// rtl/sad_pkg.sv - shared state encoding and derived-size helpers for the SAD search engine
package sad_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_LAST  = 3'd2,
        S_CMP   = 3'd3,
        S_DONE  = 3'd4
    } sad_state_e;

    // Ceiling log2; clog2(1) == 0
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) < v) r = k + 1;
        end
        return r;
    endfunction

    function automatic int win_pix(input int ww, input int wh);
        return ww * wh;
    endfunction

    function automatic int cand_x(input int fw, input int ww);
        return fw - ww + 1;
    endfunction

    function automatic int cand_y(input int fh, input int wh);
        return fh - wh + 1;
    endfunction

    function automatic int ncand(input int fw, input int fh, input int ww, input int wh);
        return cand_x(fw, ww) * cand_y(fh, wh);
    endfunction

    // Derived constants for the default 64x64 frame / 4x4 window configuration
    localparam int DEF_WIN_PIX = win_pix(4, 4);
    localparam int DEF_CAND_X  = cand_x(64, 4);
    localparam int DEF_CAND_Y  = cand_y(64, 4);
    localparam int DEF_NCAND   = ncand(64, 64, 4, 4);

endpackage

// File: rtl/sad_scan_counter.sv
// rtl/sad_scan_counter.sv - nested pixel (i,j) and candidate (x,y) counters with address generation
module sad_scan_counter
    import sad_pkg::*;
#(
    parameter int FRAME_W = 64,
    parameter int WIN_W   = 4,
    parameter int WIN_H   = 4,
    parameter int X_LAST  = 60,
    parameter int Y_LAST  = 60,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              advance_pixel,
    input  logic              advance_candidate,
    output logic              last_pixel,
    output logic              last_candidate,
    output logic [ADDR_W-1:0] x,
    output logic [ADDR_W-1:0] y,
    output logic [ADDR_W-1:0] frame_addr,
    output logic [ADDR_W-1:0] win_addr
);

    logic [ADDR_W-1:0] i_q, i_d, j_q, j_d, x_q, x_d, y_q, y_d;

    logic i_wrap, j_wrap, x_wrap, y_wrap;

    assign i_wrap         = (i_q == ADDR_W'(WIN_W - 1));
    assign j_wrap         = (j_q == ADDR_W'(WIN_H - 1));
    assign x_wrap         = (x_q == ADDR_W'(X_LAST));
    assign y_wrap         = (y_q == ADDR_W'(Y_LAST));
    assign last_pixel     = i_wrap && j_wrap;
    assign last_candidate = x_wrap && y_wrap;

    assign x          = x_q;
    assign y          = y_q;
    assign frame_addr = (y_q + j_q) * ADDR_W'(FRAME_W) + (x_q + i_q);
    assign win_addr   = j_q * ADDR_W'(WIN_W) + i_q;

    // Next-count logic: i inner within the window, x inner across candidates
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            i_d = '0;
            j_d = '0;
            x_d = '0;
            y_d = '0;
        end else begin
            if (advance_pixel) begin
                i_d = i_wrap ? '0 : i_q + 1'b1;
                if (i_wrap) j_d = j_wrap ? '0 : j_q + 1'b1;
            end
            if (advance_candidate) begin
                x_d = x_wrap ? '0 : x_q + 1'b1;
                if (x_wrap) y_d = y_wrap ? '0 : y_q + 1'b1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            i_q <= '0;
            j_q <= '0;
            x_q <= '0;
            y_q <= '0;
        end else begin
            i_q <= i_d;
            j_q <= j_d;
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/sad_search_engine.sv
// rtl/sad_search_engine.sv - full-search block matcher returning the minimum-SAD window position
module sad_search_engine
    import sad_pkg::*;
#(
    parameter int PIX_W   = 8,
    parameter int FRAME_W = 64,
    parameter int FRAME_H = 64,
    parameter int WIN_W   = 4,
    parameter int WIN_H   = 4,
    parameter int ADDR_W  = 16,
    parameter int SAD_W   = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              frame_rd_en,
    output logic [ADDR_W-1:0] frame_addr,
    input  logic [PIX_W-1:0]  frame_rd_data,
    output logic              win_rd_en,
    output logic [ADDR_W-1:0] win_addr,
    input  logic [PIX_W-1:0]  win_rd_data,
    output logic [31:0]       xCoord,
    output logic [31:0]       yCoord,
    output logic [31:0]       sad
);

    localparam int WIN_PIX = win_pix(WIN_W, WIN_H);
    localparam int X_LAST  = FRAME_W - WIN_W;
    localparam int Y_LAST  = FRAME_H - WIN_H;

    if (SAD_W < PIX_W + clog2(WIN_PIX) || SAD_W > 32 ||
        (64'd1 << ADDR_W) < 64'(FRAME_W * FRAME_H) ||
        WIN_W < 1 || WIN_H < 1 || WIN_W > FRAME_W || WIN_H > FRAME_H) begin : g_bad_params
        $error("sad_search_engine: illegal parameter combination");
    end

    sad_state_e        state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic              rd_valid_q, rd_valid_d;
    logic [SAD_W-1:0]  acc_q, acc_d;
    logic [SAD_W-1:0]  best_q, best_d;
    logic [ADDR_W-1:0] bx_q, bx_d, by_q, by_d;
    logic [31:0]       x_coord_q, x_coord_d, y_coord_q, y_coord_d, sad_q, sad_d;

    logic              cnt_clear, adv_pixel, adv_cand;
    logic              last_pixel, last_candidate;
    logic [ADDR_W-1:0] cur_x, cur_y;
    logic [PIX_W:0]    fe, we, abs_diff;

    sad_scan_counter #(
        .FRAME_W (FRAME_W),
        .WIN_W   (WIN_W),
        .WIN_H   (WIN_H),
        .X_LAST  (X_LAST),
        .Y_LAST  (Y_LAST),
        .ADDR_W  (ADDR_W)
    ) u_scan (
        .clk               (Clk),
        .resetn            (Reset),
        .clear             (cnt_clear),
        .advance_pixel     (adv_pixel),
        .advance_candidate (adv_cand),
        .last_pixel        (last_pixel),
        .last_candidate    (last_candidate),
        .x                 (cur_x),
        .y                 (cur_y),
        .frame_addr        (frame_addr),
        .win_addr          (win_addr)
    );

    assign fe       = {1'b0, frame_rd_data};
    assign we       = {1'b0, win_rd_data};
    assign abs_diff = (fe >= we) ? (fe - we) : (we - fe);

    assign busy        = busy_q;
    assign done        = done_q;
    assign frame_rd_en = rd_en_q;
    assign win_rd_en   = rd_en_q;
    assign xCoord      = x_coord_q;
    assign yCoord      = y_coord_q;
    assign sad         = sad_q;

    // Next-state, accumulate and best-compare logic; read data lands one cycle after its strobe
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rd_en_d    = 1'b0;
        rd_valid_d = rd_en_q;
        acc_d      = acc_q;
        best_d     = best_q;
        bx_d       = bx_q;
        by_d       = by_q;
        x_coord_d  = x_coord_q;
        y_coord_d  = y_coord_q;
        sad_d      = sad_q;
        cnt_clear  = 1'b0;
        adv_pixel  = 1'b0;
        adv_cand   = 1'b0;

        if (rd_valid_q) acc_d = acc_q + SAD_W'(abs_diff);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_ISSUE;
                    busy_d    = 1'b1;
                    acc_d     = '0;
                    best_d    = '1;
                    cnt_clear = 1'b1;
                    rd_en_d   = 1'b1;
                end
            end
            S_ISSUE: begin
                adv_pixel = 1'b1;
                if (last_pixel) state_d = S_LAST;
                else            rd_en_d = 1'b1;
            end
            S_LAST: begin
                state_d = S_CMP;
            end
            S_CMP: begin
                if (acc_q < best_q) begin
                    best_d = acc_q;
                    bx_d   = cur_x;
                    by_d   = cur_y;
                end
                acc_d    = '0;
                adv_cand = 1'b1;
                if (last_candidate) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ISSUE;
                    rd_en_d = 1'b1;
                end
            end
            S_DONE: begin
                x_coord_d = 32'(bx_q);
                y_coord_d = 32'(by_q);
                sad_d     = 32'(best_q);
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM and datapath registers; reset abandons any search in flight
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            acc_q      <= '0;
            best_q     <= '0;
            bx_q       <= '0;
            by_q       <= '0;
            x_coord_q  <= '0;
            y_coord_q  <= '0;
            sad_q      <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_en_q    <= rd_en_d;
            rd_valid_q <= rd_valid_d;
            acc_q      <= acc_d;
            best_q     <= best_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            x_coord_q  <= x_coord_d;
            y_coord_q  <= y_coord_d;
            sad_q      <= sad_d;
        end
    end

endmodule

// File: doc/sad_search_engine.md
Name: sad_search_engine

Overview:
- Hardware full-search block-matching engine: finds the frame position whose WIN_W x WIN_H patch has minimum sum of absolute differences (SAD) against a stored window.
- Replaces the software SAD loop on the pipelined core. Result ports keep the core's names: xCoord, yCoord, sad.
- Reads the frame and window through two synchronous read ports with 1-cycle latency.
- Generalises the fixed search in frame size, window size and pixel width.

Parameters:
PIX_W, 8, pixel width in bits
FRAME_W, 64, frame width in pixels
FRAME_H, 64, frame height in pixels
WIN_W, 4, window width in pixels
WIN_H, 4, window height in pixels
ADDR_W, 16, address width; must satisfy 2^ADDR_W >= FRAME_W*FRAME_H
SAD_W, 32, accumulator width; must be >= PIX_W+clog2(WIN_W*WIN_H) and <= 32

Ports:
Clk  in  1  clock
Reset  in  1  synchronous, active-low reset
start  in  1  begin search; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until DONE
done  out  1  one-cycle pulse; result valid
frame_rd_en  out  1  frame read strobe
frame_addr  out  ADDR_W  linear frame address, (y+j)*FRAME_W+(x+i)
frame_rd_data  in  PIX_W  frame pixel, valid 1 cycle after strobe
win_rd_en  out  1  window read strobe
win_addr  out  ADDR_W  window address, j*WIN_W+i
win_rd_data  in  PIX_W  window pixel, valid 1 cycle after strobe
xCoord  out  32  best x, zero-extended
yCoord  out  32  best y, zero-extended
sad  out  32  best SAD, zero-extended

Behaviour:
- Reset (Reset==0 at a Clk edge):
  - State goes to IDLE.
  - busy, done, frame_rd_en, win_rd_en, xCoord, yCoord and sad all go to 0.
  - Addresses go to 0.
  - Reset mid-search abandons the search; no done is produced.
- Candidates: x in 0..FRAME_W-WIN_W, y in 0..FRAME_H-WIN_H. Scan is raster order, x inner.
  - NCAND = (FRAME_W-WIN_W+1)*(FRAME_H-WIN_H+1).
- States: IDLE, ISSUE, LAST, CMP, DONE.
  - IDLE: on start=1, clear x, y, i, j and acc. Set best to all-ones (SAD_W bits). Go to ISSUE.
  - ISSUE: lasts WIN_W*WIN_H cycles, one read per cycle on both ports, i inner.
    - The data returned from the previous issue cycle is accumulated: acc += |frame_rd_data - win_rd_data|. The difference is computed unsigned, at PIX_W+1 bits.
    - After the issue with i=WIN_W-1, j=WIN_H-1, go to LAST.
  - LAST: strobes low; accumulate the final pixel. Go to CMP.
  - CMP: if acc < best (strict), load best, bx and by from acc, x and y.
    - Ties keep the earlier candidate.
    - Clear acc and advance the candidate.
    - If this was the last candidate, go to DONE; else go to ISSUE.
  - DONE: update xCoord, yCoord and sad from bx, by and best. done=1 and busy=0 this cycle. Go to IDLE.
- Latency: K = WIN_W*WIN_H+2 cycles per candidate.
  - With start accepted at edge 0, done is high in the cycle after edge NCAND*K+1.
- Results hold their values until the next DONE or reset.
- start while busy is ignored. start held high through DONE restarts the search on the next IDLE cycle.
- Accumulator cannot overflow, given the SAD_W constraint. Parameter violations are caught by an elaboration-time check.

Decomposition:
- Shared package sad_pkg holds:
  - the state encoding (IDLE..DONE);
  - derived constants NCAND, WIN_PIX=WIN_W*WIN_H and the candidate counts on each axis;
  - a clog2 function.
- One sub-module, sad_scan_counter: nested i/j/x/y counters with advance_pixel and advance_candidate inputs. It outputs last_pixel, last_candidate and both addresses.
- The abs-diff, accumulator and best-compare logic stays in the top.

Test Plan:
1. Reset low for 2 cycles with start=1 -> busy=done=0, xCoord=yCoord=sad=0, strobes 0, no search starts.
2. Parameters FRAME 8x8, WIN 2x2, PIX_W=8. Frame = pixel index mod 251; window copied from the patch at (3,5); start pulse -> done high in the cycle after edge 49*6+1=295, xCoord=3, yCoord=5, sad=0.
3. Same parameters, frame and window all 0 -> every SAD ties at 0; required result xCoord=0, yCoord=0, sad=0 (first candidate wins).
4. Same parameters, frame all 255, window all 0 -> sad=1020, xCoord=0, yCoord=0. Also checks that no overflow occurs at SAD_W.
5. Reset driven low during the 50th cycle of a search -> next cycle busy=0, done never pulses, outputs 0. A new start then completes with correct results.
6. start pulsed again at cycles 10 and 200 of a search -> ignored; exactly one done, at cycle 295. Holding start high across DONE -> second done 296 cycles later.
